// File: rtl/wb_io_pkg.sv
// Shared register offsets, reset values and bus request type for the Wishbone GPIO bridge.
package wb_io_pkg;

    localparam logic [7:0] OFS_OUT    = 8'h00;
    localparam logic [7:0] OFS_OEB    = 8'h04;
    localparam logic [7:0] OFS_IN     = 8'h08;
    localparam logic [7:0] OFS_EDGE   = 8'h0C;
    localparam logic [7:0] OFS_IRQ_EN = 8'h10;
    localparam logic [7:0] OFS_ID     = 8'h14;

    // Pads come out of reset undriven.
    localparam logic [31:0] RST_OUT    = 32'h0000_0000;
    localparam logic [31:0] RST_OEB    = 32'hFFFF_FFFF;
    localparam logic [31:0] RST_IRQ_EN = 32'h0000_0000;
    localparam logic [31:0] RST_EDGE   = 32'h0000_0000;

    typedef enum logic {ST_IDLE, ST_ACK} ack_state_e;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
    } wb_req_t;

    function automatic logic [31:0] sel_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/wb_io_bridge_io_sync.sv
// Per-pin input synchroniser chain with a single-cycle rising-edge pulse on the synchronised value.
module io_sync #(
    parameter int NPINS       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NPINS-1:0] d,
    output logic [NPINS-1:0] q,
    output logic [NPINS-1:0] rise
);

    logic [NPINS-1:0] q_prev;

    for (genvar i = 0; i < NPINS; i++) begin : g_pin
        logic [SYNC_STAGES-1:0] chain;

        always_ff @(posedge clk) begin
            if (!rst_n) chain <= '0;
            else        chain <= {chain[SYNC_STAGES-2:0], d[i]};
        end

        assign q[i] = chain[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) q_prev <= '0;
        else        q_prev <= q;
    end

    assign rise = q & ~q_prev;

endmodule

// File: rtl/wb_io_bridge.sv
// Single-beat registered Wishbone slave exposing NPINS GPIO pads with OE control,
// synchronised inputs, sticky rising-edge capture and a maskable level interrupt.
module wb_io_bridge
    import wb_io_pkg::*;
#(
    parameter int          NPINS       = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] ID_VALUE    = 32'h5350_0001
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             wbs_cyc_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    input  logic             active,
    input  logic [NPINS-1:0] io_in,
    output logic [NPINS-1:0] io_out,
    output logic [NPINS-1:0] io_oeb,
    output logic             irq_o,
    output logic [31:0]      la_data_out
);

    wb_req_t          req;
    ack_state_e       state, state_nx;
    logic             hit, take, wr;
    logic [7:0]       ofs;
    logic [31:0]      mask32, rdata, dat_q;
    logic [NPINS-1:0] wmask, wdat;
    logic [NPINS-1:0] out_q, oeb_q, irq_en_q, edge_q;
    logic [NPINS-1:0] in_q, rise;
    logic             irq_q;
    logic             unused_hi;

    assign req = '{cyc: wbs_cyc_i, stb: wbs_stb_i, we: wbs_we_i,
                   sel: wbs_sel_i, adr: wbs_adr_i, dat: wbs_dat_i};

    assign hit    = req.cyc & req.stb & active & (req.adr[31:8] == BASE_ADDR[31:8]);
    assign ofs    = req.adr[7:0];
    assign mask32 = sel_mask(req.sel);
    assign wmask  = mask32[NPINS-1:0];
    assign wdat   = req.dat[NPINS-1:0];
    assign wr     = take & req.we;

    // Data bits above NPINS have no register behind them.
    assign unused_hi = ^{req.dat, mask32};

    io_sync #(
        .NPINS      (NPINS),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_io_sync (
        .clk  (wb_clk_i),
        .rst_n(wb_rst_ni),
        .d    (io_in),
        .q    (in_q),
        .rise (rise)
    );

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) state <= ST_IDLE;
        else            state <= state_nx;
    end

    // ACK always falls back to IDLE, so back-to-back strobes ack every other cycle.
    always_comb begin
        state_nx = state;
        take     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (hit) begin
                    state_nx = ST_ACK;
                    take     = 1'b1;
                end
            end
            ST_ACK:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        rdata = '0;
        case (ofs)
            OFS_OUT:    rdata[NPINS-1:0] = out_q;
            OFS_OEB:    rdata[NPINS-1:0] = oeb_q;
            OFS_IN:     rdata[NPINS-1:0] = in_q;
            OFS_EDGE:   rdata[NPINS-1:0] = edge_q;
            OFS_IRQ_EN: rdata[NPINS-1:0] = irq_en_q;
            OFS_ID:     rdata            = ID_VALUE;
            default:    rdata            = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            out_q    <= RST_OUT[NPINS-1:0];
            oeb_q    <= RST_OEB[NPINS-1:0];
            irq_en_q <= RST_IRQ_EN[NPINS-1:0];
            edge_q   <= RST_EDGE[NPINS-1:0];
            dat_q    <= '0;
            irq_q    <= 1'b0;
        end else begin
            dat_q <= (take && !req.we) ? rdata : '0;
            if (wr && ofs == OFS_OUT)    out_q    <= (out_q    & ~wmask) | (wdat & wmask);
            if (wr && ofs == OFS_OEB)    oeb_q    <= (oeb_q    & ~wmask) | (wdat & wmask);
            if (wr && ofs == OFS_IRQ_EN) irq_en_q <= (irq_en_q & ~wmask) | (wdat & wmask);
            // A fresh rising edge beats a coincident write-1-to-clear.
            edge_q <= (edge_q & ~((wr && ofs == OFS_EDGE) ? (wdat & wmask) : '0)) | rise;
            irq_q  <= |(edge_q & irq_en_q);
        end
    end

    assign wbs_ack_o = (state == ST_ACK);
    assign wbs_dat_o = dat_q;
    assign irq_o     = irq_q;
    assign io_out    = active ? out_q : '0;
    assign io_oeb    = active ? oeb_q : '1;

    always_comb begin
        la_data_out            = '0;
        la_data_out[NPINS-1:0] = in_q;
    end

endmodule

// File: tb/tb_wb_io_bridge.sv
// Directed bench for wb_io_bridge: read-data scoreboard checked on every ack, plus pad/irq checks.
module tb_wb_io_bridge;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst_n, cyc, stb, wen, active;
    logic [3:0]  sel;
    logic [31:0] adr, dat;
    logic        ack, irq;
    logic [31:0] dat_o, la;
    logic [7:0]  io_in, io_out, io_oeb;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    wb_io_bridge #(
        .NPINS      (8),
        .BASE_ADDR  (BASE),
        .SYNC_STAGES(2),
        .ID_VALUE   (32'h5350_0001)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .wbs_cyc_i  (cyc),
        .wbs_stb_i  (stb),
        .wbs_we_i   (wen),
        .wbs_sel_i  (sel),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (dat),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (dat_o),
        .active     (active),
        .io_in      (io_in),
        .io_out     (io_out),
        .io_oeb     (io_oeb),
        .irq_o      (irq),
        .la_data_out(la)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every ack pops one expected read value.
    always @(negedge clk) begin
        if (ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_ack: ack with data %h, none expected at %0t", dat_o, $time);
            end else begin
                check("rdata", dat_o, exp_q.pop_front());
            end
        end
    end

    // One single-beat cycle; exp is the read data (writes return 0) when an ack is expected.
    task automatic wb(input logic [31:0] a, input logic we, input logic [31:0] d,
                      input logic [3:0] s, input logic [31:0] exp, input logic acks);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; adr = a; wen = we; dat = d; sel = s;
        if (acks) exp_q.push_back(exp);
        @(posedge clk); #1;
        check("ack", {31'b0, ack}, {31'b0, acks});
        cyc = 1'b0; stb = 1'b0; wen = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; wen = 1'b0; sel = 4'h0;
        adr = '0; dat = '0; active = 1'b1; io_in = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        check("rst_oeb", {24'b0, io_oeb}, 32'h0000_00FF);
        check("rst_out", {24'b0, io_out}, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        check("rst_ack", {31'b0, ack}, 32'h0);
        check("rst_dat", dat_o, 32'h0);
        wb(BASE + 32'h14, 1'b0, 32'h0, 4'hF, 32'h5350_0001, 1'b1);

        // OEB / OUT writes with byte selects
        wb(BASE + 32'h04, 1'b1, 32'h0000_000F, 4'b0001, 32'h0, 1'b1);
        check("oeb_wr", {24'b0, io_oeb}, 32'h0F);
        wb(BASE + 32'h00, 1'b1, 32'h0000_00A5, 4'b0001, 32'h0, 1'b1);
        check("out_wr", {24'b0, io_out}, 32'hA5);
        wb(BASE + 32'h00, 1'b1, 32'h0000_3C5A, 4'b0010, 32'h0, 1'b1);
        check("out_sel", {24'b0, io_out}, 32'hA5);
        wb(BASE + 32'h00, 1'b0, 32'h0, 4'hF, 32'h0000_00A5, 1'b1);
        wb(BASE + 32'h04, 1'b0, 32'h0, 4'hF, 32'h0000_000F, 1'b1);

        // Edge capture and interrupt latency
        wb(BASE + 32'h10, 1'b1, 32'h0000_0008, 4'b0001, 32'h0, 1'b1);
        @(negedge clk); io_in = 8'h08;
        @(posedge clk); #1; check("in_lat1", la, 32'h0);
        @(posedge clk); #1; check("in_lat2", la, 32'h08);
        @(posedge clk); #1; check("irq_lat3", {31'b0, irq}, 32'h0);
        @(posedge clk); #1; check("irq_lat4", {31'b0, irq}, 32'h1);
        wb(BASE + 32'h0C, 1'b0, 32'h0, 4'hF, 32'h0000_0008, 1'b1);
        wb(BASE + 32'h0C, 1'b1, 32'h0000_0008, 4'b0001, 32'h0, 1'b1);
        check("irq_clr", {31'b0, irq}, 32'h0);
        wb(BASE + 32'h0C, 1'b0, 32'h0, 4'hF, 32'h0, 1'b1);
        wb(BASE + 32'h08, 1'b1, 32'h0000_00FF, 4'hF, 32'h0, 1'b1);
        wb(BASE + 32'h08, 1'b0, 32'h0, 4'hF, 32'h0000_0008, 1'b1);

        // W1C commit edge coincides with the capture edge of a new rise on bit 0
        @(negedge clk); io_in = 8'h09;
        @(posedge clk);
        @(posedge clk);
        wb(BASE + 32'h0C, 1'b1, 32'h0000_0001, 4'b0001, 32'h0, 1'b1);
        wb(BASE + 32'h0C, 1'b0, 32'h0, 4'hF, 32'h0000_0001, 1'b1);
        wb(BASE + 32'h0C, 1'b1, 32'h0000_0001, 4'b0001, 32'h0, 1'b1);
        wb(BASE + 32'h0C, 1'b0, 32'h0, 4'hF, 32'h0, 1'b1);

        // Inactive project: safe pad values, no acks, registers retained
        @(negedge clk); active = 1'b0; #1;
        check("inact_oeb", {24'b0, io_oeb}, 32'hFF);
        check("inact_out", {24'b0, io_out}, 32'h0);
        wb(BASE + 32'h00, 1'b1, 32'h0000_0000, 4'hF, 32'h0, 1'b0);
        @(negedge clk); active = 1'b1; #1;
        check("react_out", {24'b0, io_out}, 32'hA5);
        check("react_oeb", {24'b0, io_oeb}, 32'h0F);

        // Window decode
        wb(BASE + 32'h100, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0);
        wb(BASE + 32'h20, 1'b0, 32'h0, 4'hF, 32'h0, 1'b1);
        wb(BASE + 32'h20, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);
        wb(BASE + 32'h14, 1'b1, 32'h0000_0000, 4'hF, 32'h0, 1'b1);
        wb(BASE + 32'h14, 1'b0, 32'h0, 4'hF, 32'h5350_0001, 1'b1);

        // Reset asserted during the ack cycle
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; adr = BASE; wen = 1'b0; sel = 4'hF;
        exp_q.push_back(32'h0000_00A5);
        @(posedge clk); #1;
        check("ack_pre_rst", {31'b0, ack}, 32'h1);
        cyc = 1'b0; stb = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_ack_drop", {31'b0, ack}, 32'h0);
        check("rst_out_clr", {24'b0, io_out}, 32'h0);
        check("rst_oeb_set", {24'b0, io_oeb}, 32'hFF);
        @(negedge clk); rst_n = 1'b1;
        wb(BASE + 32'h00, 1'b0, 32'h0, 4'hF, 32'h0, 1'b1);

        repeat (2) @(posedge clk);
        check("sb_drain", exp_q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_io_bridge.md
# wb_io_bridge

Parametrised Wishbone-to-GPIO bridge for user-project wrappers. Unlike fixed-direction wrappers, it exposes NPINS pads with software-programmable output-enable, synchronised inputs, sticky rising-edge capture and a maskable interrupt, all behind a registered single-beat Wishbone slave. It sits between the top-level tristate gating, driven by `active`, and the project logic.

## Interface
- NPINS, 8, pad count, 1..32
- BASE_ADDR, 32'h3000_0000, Wishbone window base, 256-byte aligned
- SYNC_STAGES, 2, input synchroniser depth, >=2
- ID_VALUE, 32'h5350_0001, constant returned at offset 0x14
- wb_clk_i  in  1  system clock
- wb_rst_ni  in  1  reset, synchronous, active-low
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone cycle, strobe, write
- wbs_sel_i  in  4  byte selects
- wbs_adr_i, wbs_dat_i  in  32 each  address, write data
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- active  in  1  project selected
- io_in  in  NPINS  pad inputs
- io_out, io_oeb  out  NPINS each  pad output, output-enable-bar
- irq_o  out  1  interrupt, level
- la_data_out  out  32  IN register zero-extended

## Operation
- Register map, offset from BASE_ADDR: 0x00 OUT rw; 0x04 OEB rw; 0x08 IN ro; 0x0C EDGE rw1c; 0x10 IRQ_EN rw; 0x14 ID ro. Registers are NPINS wide; upper read bits are 0.
- Decode: hit = cyc & stb & active & (adr[31:8] == BASE_ADDR[31:8]). Unmapped offsets within the window ack, read 0, and ignore writes. Misses never ack.
- Writes honour wbs_sel_i per byte. Writes to IN and ID are ignored.
- Inputs pass through a SYNC_STAGES flop chain into IN. EDGE[i] sets on IN[i] rising, i.e. previous value 0 and current value 1.
- irq_o = registered |(EDGE & IRQ_EN).
- io_out = OUT and io_oeb = OEB when active=1. When active=0, io_out=0 and io_oeb all 1. Register contents are retained while inactive.
- Reset values: OUT=0, OEB=all 1 (pads Hi-Z), IRQ_EN=0, EDGE=0, sync chain and IN=0, wbs_ack_o=0, wbs_dat_o=0, irq_o=0.

## Timing
- Ack FSM has two states. IDLE: a hit moves to ACK, asserts wbs_ack_o at the next edge for exactly 1 cycle, and commits the write at that same edge. ACK: returns to IDLE unconditionally. Back-to-back strobes therefore ack every other cycle.
- wbs_dat_o is registered together with ack. It is valid only while ack=1 and is 0 otherwise.
- OUT/OEB writes appear on io_out/io_oeb at the edge where ack asserts.
- Input-to-IN latency is SYNC_STAGES cycles. EDGE sets 1 cycle after that. irq_o follows 1 cycle after EDGE.
- A W1C on EDGE that coincides with a new rising edge on the same bit leaves the bit set: set wins.
- Reset mid-transaction: ack drops and all registers reset in the same cycle. The master must retry.
- If active drops while in ACK, the ack still completes. No new hit is taken until active=1.
- If cyc drops before ack, no write is committed; the FSM still passes through ACK, and the ack is ignored by the master.

## Structure
- Package wb_io_pkg holds the offset localparams (OFS_OUT … OFS_ID) and the reset-value constants.
- One sub-module, io_sync: a parametrised NPINS×SYNC_STAGES synchroniser plus rising-edge pulse output, instantiated once.
- Top-level tristating on `active` stays in the wrapper. This block drives only the forced-safe values described above.

## Test plan
- Reset: after wb_rst_ni low for 2 cycles, io_oeb=8'hFF, io_out=0, irq_o=0, and a read of 0x14 returns 32'h5350_0001 with ack exactly 1 cycle after the strobe.
- Write OEB=8'h0F then OUT=8'hA5 with sel=4'b0001 -> io_oeb=8'h0F and io_out=8'hA5 at the ack edge. A write with sel=4'b0010 leaves OUT unchanged.
- Drive io_in[3] 0→1 with IRQ_EN=8'h08 -> IN[3]=1 after 2 cycles, EDGE=8'h08 at cycle 3, irq_o=1 at cycle 4. W1C 8'h08 -> irq_o=0 two cycles later.
- A W1C on EDGE in the same cycle as a new rising edge on bit 0 -> EDGE[0] remains 1.
- active=0: io_oeb=all 1, io_out=0, and a strobe to 0x00 is never acked. Set active=1 -> the prior OUT value reappears.
- Address BASE_ADDR+0x100 -> no ack. Offset 0x20 -> ack with data 0. Assert wb_rst_ni low in the ack cycle -> ack=0 and OUT=0 on the next edge.
